// File: rtl/quad_gen.sv
// -----------------------------------------------------------------------------
// quad_gen -- quadrature step generator
//
// On a start command the block emits a number of gray-code transitions on
// (A,B). Transitions are spaced a programmable number of clocks apart, and
// the direction sets the sequence order:
//     forward : 00 -> 01 -> 11 -> 10 -> 00
//     reverse : the exact inverse.
// The A/B phase is kept between commands, so a new command carries on from
// wherever the previous one stopped.
//
// Parameters
//   CNT_W      width of the step count and of the remaining counter
//   DIV_W      width of the step-period divider
//
// Ports
//   hwclk      clock; all state changes happen on its rising edge
//   reset_n    asynchronous active-low reset
//   start      command strobe; only sampled while idle
//   dir        1 = forward (+1), 0 = reverse (-1)
//   steps      number of transitions to emit
//   period     clocks between transitions (0 behaves as 1)
//   abort      ends the active command at once: no further step, no done
//   A, B       registered quadrature outputs
//   busy       high while a command is running
//   done       one-cycle pulse when a command completes normally
//   remaining  number of transitions still to emit
//   position   (only with QUAD_GEN_POSITION_EN) signed 32-bit step position
//
// Optional feature: define QUAD_GEN_POSITION_EN to add the position output.
// -----------------------------------------------------------------------------
module quad_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             hwclk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] period,
    input  logic             abort,
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic             done,
`ifdef QUAD_GEN_POSITION_EN
    output logic signed [31:0] position,
`endif
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               step_s;
`ifdef QUAD_GEN_POSITION_EN
    logic signed [31:0] pos_q, pos_d;
`endif

    // Next-state, divider, counter and phase computation.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        period_d = period_q;
        div_d    = div_q;
        rem_d    = rem_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = 1'b0;
        step_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d    = dir;
                    period_d = (period == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : period;
                    // Divider starts at 1 so the first step lands exactly
                    // period clocks after the accept edge.
                    div_d    = {{(DIV_W-1){1'b0}}, 1'b1};
                    rem_d    = steps;
                    state_d  = (steps != {CNT_W{1'b0}}) ? RUN : DONE;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort beats a step that is due on the same edge.
                    state_d = IDLE;
                end else if (div_q == period_q) begin
                    step_s = 1'b1;
                    div_d  = {{(DIV_W-1){1'b0}}, 1'b1};
                    rem_d  = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    // Gray stepping: on equal bits forward moves B and
                    // reverse moves A; on unequal bits it is the other one.
                    if (dir_q == (a_q == b_q)) begin
                        b_d = ~b_q;
                    end else begin
                        a_d = ~a_q;
                    end
                    if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

`ifdef QUAD_GEN_POSITION_EN
    // Position tracks every emitted step, wrapping in two's complement.
    always_comb begin
        pos_d = pos_q;
        if (step_s) begin
            pos_d = dir_q ? (pos_q + 32'sd1) : (pos_q - 32'sd1);
        end else begin
            pos_d = pos_q;
        end
    end

    // Position register.
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q <= 32'sd0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign position = pos_q;
`endif

    // State, command latch and output registers.
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            period_q <= {DIV_W{1'b0}};
            div_q    <= {DIV_W{1'b0}};
            rem_q    <= {CNT_W{1'b0}};
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_quad_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_gen -- self-checking bench for quad_gen.
// The reference model counts completed steps arithmetically: after edge k of
// a command, n = min(k / P, steps) steps have been emitted, and the phase is
// the start index +/- n on the gray circle 00,01,11,10.
// Narrow counter widths keep the all-ones boundary commands short.
// -----------------------------------------------------------------------------
module tb_quad_gen;
    localparam int CW = 8;
    localparam int DW = 8;

    logic          hwclk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          dir;
    logic [CW-1:0] steps;
    logic [DW-1:0] period;
    logic          abort;
    logic          A;
    logic          B;
    logic          busy;
    logic          done;
    logic [CW-1:0] remaining;
`ifdef QUAD_GEN_POSITION_EN
    logic signed [31:0] position;
`endif

    quad_gen #(.CNT_W(CW), .DIV_W(DW)) dut (
        .hwclk     (hwclk),
        .reset_n   (reset_n),
        .start     (start),
        .dir       (dir),
        .steps     (steps),
        .period    (period),
        .abort     (abort),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
`ifdef QUAD_GEN_POSITION_EN
        .position  (position),
`endif
        .remaining (remaining)
    );

    always #5 hwclk = ~hwclk;

    int checks   = 0;
    int failures = 0;
    int model_phase = 0;
    int model_pos   = 0;

    function automatic logic [1:0] gray_of(input int idx);
        case (idx & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int idx_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Simple quadrature decoder watching the outputs.
    int         dec_count = 0;
    bit         dec_err   = 1'b0;
    logic [1:0] dec_prev  = 2'b00;
    always @(posedge hwclk) begin
        if (!reset_n) begin
            dec_prev <= 2'b00;
        end else begin
            case ((idx_of({A, B}) - idx_of(dec_prev)) & 3)
                1:       dec_count <= dec_count + 1;
                3:       dec_count <= dec_count - 1;
                2:       dec_err   <= 1'b1;
                default: ;
            endcase
            dec_prev <= {A, B};
        end
    end

    // Runs one command and compares every cycle against the model.
    // abort_at = edge index (after accept edge 0) at which abort is high, 0 = none.
    // junk = throw random start commands at the block while it is busy/done.
    task automatic run_cmd(input bit d, input int st, input int per, input int abort_at, input bit junk);
        int p;
        int end_edge;
        int last;
        int n;
        bit aborted;
        logic [1:0] e_ab;
        p        = (per == 0) ? 1 : per;
        end_edge = st * p + 1;
        last     = (abort_at > 0) ? abort_at : end_edge;
        n        = 0;
        for (int k = 0; k <= last + 2; k++) begin
            if (k == 0) begin
                start = 1'b1; dir = d; steps = CW'(st); period = DW'(per); abort = 1'b0;
            end else begin
                abort = (k == abort_at);
                if (junk && k <= last) begin
                    start  = 1'($urandom_range(0, 1));
                    dir    = 1'($urandom_range(0, 1));
                    steps  = CW'($urandom_range(1, 255));
                    period = DW'($urandom_range(0, 255));
                end else begin
                    start = 1'b0;
                end
            end
            @(posedge hwclk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            aborted = (abort_at > 0) && (k >= abort_at);
            if (aborted) n = (abort_at - 1) / p;
            else         n = ((k / p) < st) ? (k / p) : st;
            e_ab = gray_of(model_phase + (d ? n : -n));
            check($sformatf("cyc%0d", k),
                  {52'd0, A, B, busy, done, remaining},
                  {52'd0, e_ab, (!aborted && st != 0 && n < st), (!aborted && k == end_edge), CW'(st - n)});
`ifdef QUAD_GEN_POSITION_EN
            check($sformatf("pos%0d", k), 64'(position), 64'(model_pos + (d ? n : -n)));
`endif
        end
        model_phase = (model_phase + (d ? n : -n)) & 3;
        model_pos   = model_pos + (d ? n : -n);
    endtask

    typedef struct {
        bit         d;
        int         st;
        int         per;
        int         abort_at;
        bit         junk;
        logic [1:0] exp_ab;
        int         exp_rem;
    } vec_t;

    vec_t vecs[9];
    int   c0;

    initial begin
        // Hand-derived end states, chained from the reset phase 00.
        vecs[0] = '{1'b1,   4,   3, 0, 1'b0, 2'b00, 0};  // 01,11,10,00 at 3,6,9,12
        vecs[1] = '{1'b0,   5,   0, 0, 1'b0, 2'b10, 0};  // 10,11,01,00,10
        vecs[2] = '{1'b1,   0,   5, 0, 1'b0, 2'b10, 0};  // no motion
        vecs[3] = '{1'b1,  10,   2, 7, 1'b1, 2'b11, 7};  // abort after 3rd step
        vecs[4] = '{1'b1,   3,   1, 0, 1'b1, 2'b01, 0};
        vecs[5] = '{1'b0, 255,   1, 0, 1'b0, 2'b11, 0};  // max steps
        vecs[6] = '{1'b1,   2, 255, 0, 1'b0, 2'b00, 0};  // max period
        vecs[7] = '{1'b0,   3,   2, 6, 1'b0, 2'b11, 1};  // abort on a due step
        vecs[8] = '{1'b1,   1,   1, 0, 1'b0, 2'b10, 0};

        reset_n = 1'b0; start = 1'b0; dir = 1'b0; steps = '0; period = '0; abort = 1'b0;
        repeat (2) @(posedge hwclk);
        #1;
        check("reset_state", {60'd0, A, B, busy, done}, 64'd0);
        check("reset_rem", 64'(remaining), 64'd0);
        @(negedge hwclk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].d, vecs[i].st, vecs[i].per, vecs[i].abort_at, vecs[i].junk);
            check($sformatf("vec%0d_ab", i), 64'({A, B}), 64'(vecs[i].exp_ab));
            check($sformatf("vec%0d_rem", i), 64'(remaining), 64'(vecs[i].exp_rem));
        end

        // Decoder follows a forward 8-step command.
        c0 = dec_count;
        run_cmd(1'b1, 8, 1, 0, 1'b0);
        @(posedge hwclk);
        #1;
        check("dec_count", 64'(dec_count - c0), 64'd8);

        // Randomized commands.
        for (int r = 0; r < 25; r++) begin
            int d, st, per, p, ab;
            d   = $urandom_range(0, 1);
            st  = $urandom_range(0, 12);
            per = $urandom_range(0, 4);
            p   = (per == 0) ? 1 : per;
            ab  = (st > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, st * p) : 0;
            run_cmd(1'(d), st, per, ab, 1'($urandom_range(0, 1)));
        end
        check("dec_err", 64'(dec_err), 64'd0);

        // Reset in the middle of a command, no clock edge needed.
        start = 1'b1; dir = 1'b1; steps = CW'(20); period = DW'(1);
        @(posedge hwclk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge hwclk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {60'd0, A, B, busy, done}, 64'd0);
        check("async_rem", 64'(remaining), 64'd0);
`ifdef QUAD_GEN_POSITION_EN
        check("async_pos", 64'(position), 64'd0);
`endif
        @(negedge hwclk);
        reset_n = 1'b1;
        model_phase = 0;
        model_pos   = 0;
        run_cmd(1'b0, 3, 2, 0, 1'b0);  // accepted on the first clock after release
        check("post_reset_ab", 64'({A, B}), 64'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
